// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared channel state encoding and default parameters for clk_divider_prog
package clk_div_pkg;

   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_RUN  = 2'd1,
      CH_STOP = 2'd2
   } ch_state_t;

   localparam int MIN_DIV         = 2;
   localparam int DEF_NUM_CH      = 4;
   localparam int DEF_DIV_WIDTH   = 32;
   localparam int DEF_DEFAULT_DIV = 125000000;

endpackage

// File: rtl/clk_div_channel.sv
// rtl/clk_div_channel.sv - one divider channel: active/shadow period and high time, counter, run/stop sequencing
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
   parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
   input  logic                 clk_in,
   input  logic                 resetn,
   input  logic                 en,
   input  logic                 wr_en,
   input  logic [DIV_WIDTH-1:0] wr_div,
   input  logic [DIV_WIDTH-1:0] wr_high,
   output logic                 clk_out,
   output logic                 tick,
   output logic                 pending
);

   localparam logic [DIV_WIDTH-1:0] RST_DIV   = DIV_WIDTH'(DEFAULT_DIV);
   localparam logic [DIV_WIDTH-1:0] RST_HIGH  = DIV_WIDTH'(DEFAULT_DIV / 2);
   localparam logic [DIV_WIDTH-1:0] DIV_FLOOR = DIV_WIDTH'(MIN_DIV);
   localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);

   ch_state_t            state, state_nxt;
   logic [DIV_WIDTH-1:0] counter, counter_nxt;
   logic [DIV_WIDTH-1:0] div_act, high_act;
   logic [DIV_WIDTH-1:0] div_sh, high_sh;
   logic [DIV_WIDTH-1:0] last_cnt;
   logic                 at_last;
   logic                 apply;

   // Divisors below the floor are clamped so every period keeps a distinct start cycle.
   assign last_cnt = ((div_act < DIV_FLOOR) ? DIV_FLOOR : div_act) - ONE;
   assign at_last  = (state != CH_IDLE) && (counter == last_cnt);
   assign apply    = pending && ((state == CH_IDLE) || at_last);
   assign tick     = (state != CH_IDLE) && (counter == '0);

   always_comb begin
      state_nxt   = state;
      counter_nxt = counter;
      unique case (state)
         CH_IDLE: begin
            if (en) begin
               state_nxt   = CH_RUN;
               counter_nxt = '0;
            end
         end
         CH_RUN: begin
            counter_nxt = at_last ? '0 : counter + ONE;
            if (!en) begin
               state_nxt = at_last ? CH_IDLE : CH_STOP;
            end
         end
         CH_STOP: begin
            counter_nxt = at_last ? '0 : counter + ONE;
            if (en) begin
               state_nxt = CH_RUN;
            end else if (at_last) begin
               state_nxt = CH_IDLE;
            end
         end
         default: begin
            state_nxt   = CH_IDLE;
            counter_nxt = '0;
         end
      endcase
   end

   // Shadow moves to active only at a period boundary, so a period never changes shape midway.
   always_ff @(posedge clk_in or negedge resetn) begin
      if (!resetn) begin
         state    <= CH_IDLE;
         counter  <= '0;
         div_act  <= RST_DIV;
         high_act <= RST_HIGH;
         div_sh   <= RST_DIV;
         high_sh  <= RST_HIGH;
         pending  <= 1'b0;
         clk_out  <= 1'b0;
      end else begin
         state   <= state_nxt;
         counter <= counter_nxt;
         clk_out <= (state != CH_IDLE) && (counter < high_act);
         if (wr_en) begin
            div_sh  <= wr_div;
            high_sh <= wr_high;
            pending <= 1'b1;
         end else if (apply) begin
            div_act  <= div_sh;
            high_act <= high_sh;
            pending  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/clk_divider_prog.sv
// rtl/clk_divider_prog.sv - multi-channel programmable clock divider with shadowed per-channel configuration
module clk_divider_prog
   import clk_div_pkg::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
   parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
   input  logic                 clk_in,
   input  logic                 resetn,
   input  logic [NUM_CH-1:0]    ch_en,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [3:0]           cfg_ch,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   input  logic [DIV_WIDTH-1:0] cfg_high,
   output logic                 cfg_err,
   output logic [NUM_CH-1:0]    clk_out,
   output logic [NUM_CH-1:0]    tick,
   output logic [NUM_CH-1:0]    pending
);

   logic [15:0]       pending_all;
   logic              cfg_in_range;
   logic              cfg_accept;
   logic [NUM_CH-1:0] wr_en;

   // Unused upper slots read as not pending, so out-of-range writes are always ready.
   assign pending_all  = 16'(pending);
   assign cfg_in_range = ({1'b0, cfg_ch} < 5'(NUM_CH));
   assign cfg_ready    = !pending_all[cfg_ch];
   assign cfg_accept   = cfg_valid && cfg_ready;

   always_ff @(posedge clk_in or negedge resetn) begin
      if (!resetn) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_accept && !cfg_in_range;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign wr_en[i] = cfg_accept && (cfg_ch == 4'(i));

      clk_div_channel #(
         .DIV_WIDTH   (DIV_WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_in  (clk_in),
         .resetn  (resetn),
         .en      (ch_en[i]),
         .wr_en   (wr_en[i]),
         .wr_div  (cfg_div),
         .wr_high (cfg_high),
         .clk_out (clk_out[i]),
         .tick    (tick[i]),
         .pending (pending[i])
      );
   end

endmodule

// File: tb/tb_clk_divider_prog.sv
// tb/tb_clk_divider_prog.sv - directed and randomized checks of clk_divider_prog against a period-level model
module tb_clk_divider_prog;

   localparam int NUM_CH    = 4;
   localparam int DIV_WIDTH = 16;
   localparam int DEF_DIV   = 12;
   localparam int W         = 3 * NUM_CH + 2;

   logic                 clk_in = 1'b0;
   logic                 resetn;
   logic [NUM_CH-1:0]    ch_en;
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [3:0]           cfg_ch;
   logic [DIV_WIDTH-1:0] cfg_div;
   logic [DIV_WIDTH-1:0] cfg_high;
   logic                 cfg_err;
   logic [NUM_CH-1:0]    clk_out;
   logic [NUM_CH-1:0]    tick;
   logic [NUM_CH-1:0]    pending;
   logic [W-1:0]         obs;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: a running channel walks positions 0..period-1; it keeps running while ch_en is 1 at a period end.
   bit m_run  [NUM_CH];
   int m_pos  [NUM_CH];
   int m_div  [NUM_CH];
   int m_high [NUM_CH];
   int m_sdiv [NUM_CH];
   int m_shigh[NUM_CH];
   bit m_pend [NUM_CH];
   bit m_out  [NUM_CH];
   bit m_err;

   clk_divider_prog #(
      .NUM_CH      (NUM_CH),
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEF_DIV)
   ) dut (
      .clk_in    (clk_in),
      .resetn    (resetn),
      .ch_en     (ch_en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_high  (cfg_high),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick),
      .pending   (pending)
   );

   assign obs = {clk_out, tick, pending, cfg_ready, cfg_err};

   always #5 clk_in = ~clk_in;

   function automatic void model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_run[i]   = 1'b0;
         m_pos[i]   = 0;
         m_div[i]   = DEF_DIV;
         m_high[i]  = DEF_DIV / 2;
         m_sdiv[i]  = DEF_DIV;
         m_shigh[i] = DEF_DIV / 2;
         m_pend[i]  = 1'b0;
         m_out[i]   = 1'b0;
      end
      m_err = 1'b0;
   endfunction

   function automatic bit model_ready();
      if (int'(cfg_ch) >= NUM_CH) return 1'b1;
      return !m_pend[cfg_ch];
   endfunction

   function automatic void model_edge();
      bit acc;
      int ch;
      acc   = cfg_valid && model_ready();
      ch    = int'(cfg_ch);
      m_err = acc && (ch >= NUM_CH);
      for (int i = 0; i < NUM_CH; i++) begin
         int per;
         bit at_end;
         per      = (m_div[i] < 2) ? 2 : m_div[i];
         at_end   = m_run[i] && (m_pos[i] == per - 1);
         m_out[i] = m_run[i] && (m_pos[i] < m_high[i]);
         if (m_pend[i] && (!m_run[i] || at_end)) begin
            m_div[i]  = m_sdiv[i];
            m_high[i] = m_shigh[i];
            m_pend[i] = 1'b0;
         end else if (acc && ch == i) begin
            m_sdiv[i]  = int'(cfg_div);
            m_shigh[i] = int'(cfg_high);
            m_pend[i]  = 1'b1;
         end
         if (!m_run[i]) begin
            if (ch_en[i]) begin
               m_run[i] = 1'b1;
               m_pos[i] = 0;
            end
         end else if (at_end) begin
            m_pos[i] = 0;
            m_run[i] = ch_en[i];
         end else begin
            m_pos[i] = m_pos[i] + 1;
         end
      end
   endfunction

   function automatic logic [W-1:0] model_vec();
      logic [NUM_CH-1:0] o, t, p;
      for (int i = 0; i < NUM_CH; i++) begin
         o[i] = m_out[i];
         t[i] = m_run[i] && (m_pos[i] == 0);
         p[i] = m_pend[i];
      end
      return {o, t, p, model_ready(), m_err};
   endfunction

   task automatic step();
      @(posedge clk_in);
      if (resetn) model_edge();
      else model_reset();
      @(negedge clk_in);
   endtask

   task automatic test_reset();
      logic [W-1:0] rst_exp;
      rst_exp    = '0;
      rst_exp[1] = 1'b1;
      resetn     = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (obs !== rst_exp) begin
         n_fail++;
         $display("FAIL reset_values: dut=%b required=%b", obs, rst_exp);
      end
      for (int k = 0; k < 6; k++) begin
         resetn = (k >= 2);
         #1;
         n_checks++;
         if (obs !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_release k=%0d: dut=%b model=%b", k, obs, model_vec());
         end
         step();
      end
   endtask

   task automatic test_basic();
      for (int k = 0; k < 44; k++) begin
         cfg_valid = (k == 0);
         cfg_ch    = 4'd0;
         cfg_div   = 16'd10;
         cfg_high  = 16'd5;
         ch_en[0]  = (k >= 2);
         #1;
         n_checks++;
         if (obs !== model_vec()) begin
            n_fail++;
            $display("FAIL basic k=%0d: dut=%b model=%b", k, obs, model_vec());
         end
         n_checks++;
         if (tick[0] !== (k >= 3 && (k - 3) % 10 == 0)) begin
            n_fail++;
            $display("FAIL basic_tick k=%0d: dut=%b", k, tick[0]);
         end
         if (k >= 4) begin
            n_checks++;
            if (clk_out[0] !== ((k - 4) % 10 < 5)) begin
               n_fail++;
               $display("FAIL basic_wave k=%0d: dut=%b required=%b", k, clk_out[0], ((k - 4) % 10 < 5));
            end
         end
         step();
      end
   endtask

   task automatic test_reconfig();
      for (int k = 0; k < 25; k++) begin
         cfg_valid = (k == 2);
         cfg_ch    = 4'd0;
         cfg_div   = 16'd4;
         cfg_high  = 16'd1;
         #1;
         n_checks++;
         if (obs !== model_vec()) begin
            n_fail++;
            $display("FAIL reconfig k=%0d: dut=%b model=%b", k, obs, model_vec());
         end
         n_checks++;
         if (tick[0] !== (k >= 9 && (k - 9) % 4 == 0) || pending[0] !== (k >= 3 && k <= 8)) begin
            n_fail++;
            $display("FAIL reconfig_timing k=%0d: tick=%b pending=%b", k, tick[0], pending[0]);
         end
         if (k >= 10) begin
            n_checks++;
            if (clk_out[0] !== ((k - 10) % 4 == 0)) begin
               n_fail++;
               $display("FAIL reconfig_wave k=%0d: dut=%b required=%b", k, clk_out[0], ((k - 10) % 4 == 0));
            end
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 16; k++) begin
         cfg_valid = (k <= 4);
         cfg_ch    = 4'd0;
         cfg_div   = (k == 0) ? 16'd6 : 16'd5;
         cfg_high  = (k == 0) ? 16'd3 : 16'd2;
         #1;
         n_checks++;
         if (obs !== model_vec()) begin
            n_fail++;
            $display("FAIL b2b k=%0d: dut=%b model=%b", k, obs, model_vec());
         end
         n_checks++;
         if (pending[0] !== ((k >= 1 && k <= 3) || (k >= 5 && k <= 9)) ||
             tick[0] !== (k == 0 || k == 4 || k == 10 || k == 15)) begin
            n_fail++;
            $display("FAIL b2b_timing k=%0d: pending=%b tick=%b", k, pending[0], tick[0]);
         end
         if (k <= 4) begin
            n_checks++;
            if (cfg_ready !== (k == 0 || k == 4)) begin
               n_fail++;
               $display("FAIL b2b_ready k=%0d: dut=%b required=%b", k, cfg_ready, (k == 0 || k == 4));
            end
         end
         step();
      end
   endtask

   task automatic test_corner_div();
      for (int k = 0; k < 30; k++) begin
         cfg_valid = (k < 3);
         cfg_ch    = (k == 0) ? 4'd1 : (k == 1) ? 4'd2 : 4'd3;
         cfg_div   = (k == 0) ? 16'd0 : (k == 1) ? 16'd9 : 16'd10;
         cfg_high  = (k == 0) ? 16'd1 : (k == 1) ? 16'd0 : 16'd20;
         ch_en[3:1] = (k >= 4) ? 3'b111 : 3'b000;
         #1;
         n_checks++;
         if (obs !== model_vec()) begin
            n_fail++;
            $display("FAIL corner k=%0d: dut=%b model=%b", k, obs, model_vec());
         end
         if (k >= 6) begin
            n_checks++;
            if (clk_out[1] !== ((k - 6) % 2 == 0) || clk_out[2] !== 1'b0 || clk_out[3] !== 1'b1) begin
               n_fail++;
               $display("FAIL corner_wave k=%0d: dut=%b", k, clk_out[3:1]);
            end
         end
         step();
      end
   endtask

   task automatic test_stop();
      int stop_k = -1;
      for (int k = 0; k < 40; k++) begin
         cfg_valid = (k == 0);
         cfg_ch    = 4'd2;
         cfg_div   = 16'd8;
         cfg_high  = 16'd4;
         if (stop_k < 0 && k > 0 && m_run[2] && !m_pend[2] && m_div[2] == 8 && m_pos[2] == 3) begin
            ch_en[2] = 1'b0;
            stop_k   = k;
         end
         #1;
         n_checks++;
         if (obs !== model_vec()) begin
            n_fail++;
            $display("FAIL stop k=%0d: dut=%b model=%b", k, obs, model_vec());
         end
         if (stop_k >= 0 && k == stop_k + 1) begin
            n_checks++;
            if (clk_out[2] !== 1'b1) begin
               n_fail++;
               $display("FAIL stop_tail k=%0d: dut=%b required=1", k, clk_out[2]);
            end
         end
         if (stop_k >= 0 && k >= stop_k + 5) begin
            n_checks++;
            if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) begin
               n_fail++;
               $display("FAIL stop_idle k=%0d: clk_out=%b tick=%b required=0", k, clk_out[2], tick[2]);
            end
         end
         step();
      end
      n_checks++;
      if (stop_k < 0) begin
         n_fail++;
         $display("FAIL stop_timeout: stop point not reached, required within 40 cycles");
      end
   endtask

   task automatic test_async_reset();
      int rk = -1;
      for (int k = 0; k < 16; k++) begin
         if (rk < 0 && m_run[0] && m_pos[0] == 2) begin
            resetn = 1'b0;
            model_reset();
            rk = k;
         end
         if (rk >= 0 && k == rk + 2) resetn = 1'b1;
         #1;
         n_checks++;
         if (obs !== model_vec()) begin
            n_fail++;
            $display("FAIL async_reset k=%0d: dut=%b model=%b", k, obs, model_vec());
         end
         if (k == rk) begin
            n_checks++;
            if ({clk_out, tick, pending, cfg_err} !== '0) begin
               n_fail++;
               $display("FAIL async_reset_now k=%0d: dut=%b required=0", k, {clk_out, tick, pending, cfg_err});
            end
         end
         step();
      end
      n_checks++;
      if (rk < 0) begin
         n_fail++;
         $display("FAIL async_reset_timeout: counter=2 not reached, required within 16 cycles");
      end
   endtask

   task automatic test_bad_channel();
      for (int k = 0; k < 6; k++) begin
         cfg_valid = (k == 0);
         cfg_ch    = 4'd7;
         cfg_div   = 16'd3;
         cfg_high  = 16'd1;
         #1;
         n_checks++;
         if (obs !== model_vec()) begin
            n_fail++;
            $display("FAIL bad_ch k=%0d: dut=%b model=%b", k, obs, model_vec());
         end
         n_checks++;
         if (cfg_err !== (k == 1) || pending !== '0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_ch_err k=%0d: err=%b pending=%b ready=%b", k, cfg_err, pending, cfg_ready);
         end
         step();
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if ($urandom_range(0, 15) == 0) ch_en[i] = ~ch_en[i];
         end
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_ch    = 4'($urandom_range(0, 7));
         cfg_div   = 16'($urandom_range(0, 12));
         cfg_high  = 16'($urandom_range(0, 14));
         #1;
         n_checks++;
         if (obs !== model_vec()) begin
            n_fail++;
            $display("FAIL random k=%0d: dut=%b model=%b", k, obs, model_vec());
         end
         step();
      end
   endtask

   initial begin
      resetn    = 1'b0;
      ch_en     = '0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
      cfg_high  = '0;
      model_reset();
      @(negedge clk_in);
      test_reset();
      test_basic();
      test_reconfig();
      test_back_to_back();
      test_corner_div();
      test_stop();
      test_async_reset();
      test_bad_channel();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
